// File: rtl/mult_pkg.sv
// Shared constants, state encoding and packing helper for the 5x5 signed
// matrix-multiply sequencer and its dot-product unit.
package mult_pkg;

    localparam int DIM    = 5;
    localparam int DW     = 8;
    localparam int FLAT_W = DIM * DIM * DW;
    localparam int PROD_W = 2 * DW;
    localparam int SUM_W  = PROD_W + 3;
    localparam int IDX_W  = $clog2(FLAT_W);
    localparam int CNT_W  = $clog2(DIM);
    localparam int RIDX_W = $clog2(DIM * DIM);

    localparam logic signed [SUM_W-1:0] ELEM_MAX = 19'sd127;
    localparam logic signed [SUM_W-1:0] ELEM_MIN = -19'sd128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit offset of element (i,j) inside a row-major flattened matrix.
    function automatic logic [IDX_W-1:0] elem_lsb(input logic [CNT_W-1:0] i,
                                                  input logic [CNT_W-1:0] j);
        return IDX_W'(i) * IDX_W'(DIM * DW) + IDX_W'(j) * IDX_W'(DW);
    endfunction

endpackage

// File: rtl/dot5_signed.sv
// Combinational 5-term signed dot product with full-precision sum,
// truncated 8-bit result and out-of-range flag.
module dot5_signed
    import mult_pkg::*;
(
    input  logic [DIM-1:0][DW-1:0]   i_a,
    input  logic [DIM-1:0][DW-1:0]   i_b,
    output logic signed [SUM_W-1:0] o_sum,
    output logic [DW-1:0]           o_res,
    output logic                    o_ovf
);

    logic signed [PROD_W-1:0] w_prod [DIM];

    // NOTE: blocking assignments here build a combinational adder chain; o_sum is assigned before it is accumulated, so no latch.
    always_comb begin
        o_sum = '0;
        for (int k = 0; k < DIM; k++) begin
            w_prod[k] = PROD_W'($signed(i_a[k])) * PROD_W'($signed(i_b[k]));
            o_sum     = o_sum + SUM_W'(w_prod[k]);
        end
    end

    assign o_res = o_sum[DW-1:0];
    assign o_ovf = (o_sum > ELEM_MAX) || (o_sum < ELEM_MIN);

endmodule

// File: rtl/matrix_mult_sequencer.sv
// Sequential 5x5 signed matrix multiply: one shared dot-product unit walks
// the 25 result elements in raster order, one per cycle.
module matrix_mult_sequencer
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FLAT_W-1:0] A_flat,
    input  logic [FLAT_W-1:0] B_flat,
    output logic              busy,
    output logic              done,
    output logic [FLAT_W-1:0] C_flat,
    output logic              overflow_flag,
    output logic [RIDX_W-1:0] first_ovf_idx
);

    state_t                   r_state;
    state_t                   w_next;
    logic [FLAT_W-1:0]        r_a;
    logic [FLAT_W-1:0]        r_b;
    logic [FLAT_W-1:0]        r_c;
    logic [CNT_W-1:0]         r_row;
    logic [CNT_W-1:0]         r_col;
    logic                     r_ovf;
    logic [RIDX_W-1:0]        r_first;
    logic [DIM-1:0][DW-1:0]   w_a_row;
    logic [DIM-1:0][DW-1:0]   w_b_col;
    logic signed [SUM_W-1:0]  w_sum_unused;
    logic [DW-1:0]            w_res;
    logic                     w_ovf;
    logic                     w_last;
    logic                     w_accept;

    assign w_last   = (r_row == CNT_W'(DIM - 1)) && (r_col == CNT_W'(DIM - 1));
    assign w_accept = (r_state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first so no branch can infer a latch.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: if (start) w_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_a_row = '0;
        w_b_col = '0;
        for (int k = 0; k < DIM; k++) begin
            w_a_row[k] = r_a[elem_lsb(r_row, CNT_W'(k)) +: DW];
            w_b_col[k] = r_b[elem_lsb(CNT_W'(k), r_col) +: DW];
        end
    end

    dot5_signed u_dot (
        .i_a   (w_a_row),
        .i_b   (w_b_col),
        .o_sum (w_sum_unused),
        .o_res (w_res),
        .o_ovf (w_ovf)
    );

    // Operands are registered so the caller may change its inputs after start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_ovf   <= 1'b0;
            r_first <= '0;
        end else if (w_accept) begin
            r_a     <= A_flat;
            r_b     <= B_flat;
            r_c     <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_ovf   <= 1'b0;
            r_first <= '0;
        end else if (r_state == RUN) begin
            r_c[elem_lsb(r_row, r_col) +: DW] <= w_res;
            if (w_ovf && !r_ovf) begin
                r_ovf   <= 1'b1;
                r_first <= RIDX_W'(r_row) * RIDX_W'(DIM) + RIDX_W'(r_col);
            end
            if (r_col == CNT_W'(DIM - 1)) begin
                r_col <= '0;
                r_row <= r_row + CNT_W'(1);
            end else begin
                r_col <= r_col + CNT_W'(1);
            end
        end
    end

    assign C_flat        = r_c;
    assign overflow_flag = r_ovf;
    assign first_ovf_idx = r_first;

endmodule
